// File: rtl/count_bus_ctrl.sv
// count_bus_ctrl
//   Reader/controller for the tri-state counter bus. Enables the counter's
//   output, gates its count-enable, captures every counted value into a small
//   first-word-fall-through FIFO and counts captures taken at the wrap point.
//   While the FIFO is full the counter is stalled, so no count is lost.
//
//   Optional feature: define COUNT_SEQ_CHECK_EN to build the capture sequence
//   checker that drives seq_err. Without it seq_err is tied 0.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   start, stop   1-cycle pulses; stop wins over start
//   bus_q, rel    counter bus (valid while n_op_en=0) and wrap flag
//   n_cen         counter count-enable, active low (combinational)
//   n_op_en       counter output-enable, active low (registered)
//   rd_en         pop FIFO head
//   rd_data       FIFO head; holds the last popped value while empty
//   fifo_empty    FIFO has no entries
//   fifo_full     FIFO has DEPTH entries
//   wrap_cnt      captures taken with rel=1, saturating at 255
//   seq_err       sticky sequence error
module count_bus_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] bus_q,
  input  logic             rel,
  output logic             n_cen,
  output logic             n_op_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [7:0]       wrap_cnt,
  output logic             seq_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   OCC_ONE = 1;
  localparam logic [AW:0]   OCC_MAX = DEPTH;
  localparam logic [AW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ, occ_nxt;
  logic [WIDTH-1:0] hold_q;
  logic             push, pop, full_nxt;

  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == OCC_MAX);

  // stop gates the enable in the same cycle so the counter never advances
  // past the last captured value.
  assign n_cen = !(state == RUN && !fifo_full && !stop);

  // Every counted edge is a capture: bus_q still shows the pre-increment value.
  assign push = !n_cen;
  assign pop  = rd_en && !fifo_empty;

  always_comb begin
    occ_nxt = occ;
    if (push && !pop)      occ_nxt = occ + OCC_ONE;
    else if (!push && pop) occ_nxt = occ - OCC_ONE;
  end

  // FSM looks at next occupancy so a pop while full re-enables counting on
  // the very next cycle.
  assign full_nxt = (occ_nxt == OCC_MAX);

  assign rd_data = fifo_empty ? hold_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      n_op_en <= 1'b1;
    end else if (stop) begin
      state   <= IDLE;
      n_op_en <= 1'b1;
    end else begin
      case (state)
        IDLE:   if (start) begin
                  state   <= SETTLE;
                  n_op_en <= 1'b0;
                end
        SETTLE: state <= full_nxt ? HOLD : RUN;
        RUN:    if (full_nxt) state <= HOLD;
        HOLD:   if (!full_nxt) state <= RUN;
        default: begin
          state   <= IDLE;
          n_op_en <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      hold_q   <= '0;
      wrap_cnt <= '0;
    end else begin
      occ <= occ_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (rel && wrap_cnt != 8'hff) wrap_cnt <= wrap_cnt + 8'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        hold_q <= mem[rd_ptr];
      end
    end
  end

  // Storage needs no reset: occupancy masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_q;
  end

`ifdef COUNT_SEQ_CHECK_EN
  logic             ref_vld, prev_rel;
  logic [WIDTH-1:0] prev_q, exp_q;

  // After a capture at the wrap point the counter must restart from 0.
  assign exp_q = prev_rel ? '0 : prev_q + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_vld  <= 1'b0;
      prev_rel <= 1'b0;
      prev_q   <= '0;
      seq_err  <= 1'b0;
    end else if (state == IDLE && start && !stop) begin
      // A new run re-arms the reference; the first capture is not checked.
      ref_vld <= 1'b0;
    end else if (push) begin
      ref_vld  <= 1'b1;
      prev_q   <= bus_q;
      prev_rel <= rel;
      if (ref_vld && bus_q != exp_q) seq_err <= 1'b1;
`ifndef SYNTHESIS
      if ($isunknown(bus_q)) seq_err <= 1'b1;
`endif
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule
